// File: rtl/line_raster_engine.sv
// line_raster_engine: Bresenham rasteriser, queued line commands in, pixel stream out.
// Build macro LINE_RASTER_CLIP_EN hides pixels outside H_ACTIVE x V_ACTIVE.
module line_raster_engine #(
  parameter int XW       = 11,
  parameter int YW       = 10,
  parameter int CW       = 24,
  parameter int QDEPTH   = 2,
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 480
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [XW-1:0] cmd_x0,
  input  logic [YW-1:0] cmd_y0,
  input  logic [XW-1:0] cmd_x1,
  input  logic [YW-1:0] cmd_y1,
  input  logic [CW-1:0] cmd_color,
  output logic          px_valid,
  input  logic          px_ready,
  output logic [XW-1:0] px_x,
  output logic [YW-1:0] px_y,
  output logic [CW-1:0] px_color,
  output logic          px_last,
  output logic          done,
  output logic          busy
);

  localparam int W    = ((XW > YW) ? XW : YW) + 2;
  localparam int AW   = $clog2(QDEPTH);
  localparam int CMDW = 2 * XW + 2 * YW + CW;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_STEP  = 2'd2;

  localparam logic [W-1:0] ONE = W'(1);

  // command FIFO storage and pointers (extra MSB tells full from empty)
  logic [CMDW-1:0] mem_q [QDEPTH];
  logic [CMDW-1:0] mem_d [QDEPTH];
  logic [AW:0]     wp_q, wp_d;
  logic [AW:0]     rp_q, rp_d;
  logic            full, empty;
  logic            push, pop;

  // latched command
  logic [XW-1:0] x0_q, x0_d;
  logic [YW-1:0] y0_q, y0_d;
  logic [XW-1:0] x1_q, x1_d;
  logic [YW-1:0] y1_q, y1_d;
  logic [CW-1:0] col_q, col_d;

  // stepping state
  logic [1:0]   state_q, state_d;
  logic [W-1:0] cx_q, cx_d;
  logic [W-1:0] cy_q, cy_d;
  logic [W-1:0] dx_q, dx_d;
  logic [W-1:0] dy_q, dy_d;
  logic [W-1:0] err_q, err_d;
  logic         sxn_q, sxn_d;
  logic         syn_q, syn_d;
  logic         done_q, done_d;

  // setup and step helpers
  logic [W-1:0]   x0e, y0e, x1e, y1e;
  logic [W-1:0]   adx, ady;
  logic signed [W:0] e2, dxs, dys;
  logic           vis;
  logic           at_end;
  logic           in_step;
  logic           adv;

  assign full  = (wp_q[AW] != rp_q[AW]) &&
                 (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign empty = (wp_q == rp_q);
  assign push  = cmd_valid && !full;
  assign pop   = (state_q == S_IDLE) && !empty;

  assign x0e = {{(W-XW){1'b0}}, x0_q};
  assign y0e = {{(W-YW){1'b0}}, y0_q};
  assign x1e = {{(W-XW){1'b0}}, x1_q};
  assign y1e = {{(W-YW){1'b0}}, y1_q};

  assign adx = (x1e >= x0e) ? (x1e - x0e) : (x0e - x1e);
  assign ady = (y1e >= y0e) ? (y1e - y0e) : (y0e - y1e);

  assign e2  = $signed({err_q, 1'b0});
  assign dxs = $signed({dx_q[W-1], dx_q});
  assign dys = $signed({dy_q[W-1], dy_q});

`ifdef LINE_RASTER_CLIP_EN
  assign vis = (cx_q < W'(H_ACTIVE)) &&
               (cy_q < W'(V_ACTIVE));
`else
  assign vis = 1'b1;
`endif

  assign at_end  = (cx_q == x1e) && (cy_q == y1e);
  assign in_step = (state_q == S_STEP);
  // visible pixels wait for the sink, hidden ones step freely
  assign adv     = in_step && (vis ? px_ready : 1'b1);

  // FIFO write side and pointer update
  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    if (push) begin
      mem_d[wp_q[AW-1:0]] = {cmd_x0, cmd_y0,
                             cmd_x1, cmd_y1,
                             cmd_color};
      wp_d = wp_q + {{AW{1'b0}}, 1'b1};
    end
    if (pop) begin
      rp_d = rp_q + {{AW{1'b0}}, 1'b1};
    end
  end

  // line FSM: pop command, derive Bresenham terms, walk the line
  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    col_d   = col_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    err_d   = err_q;
    sxn_d   = sxn_q;
    syn_d   = syn_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          {x0_d, y0_d, x1_d, y1_d, col_d} =
            mem_q[rp_q[AW-1:0]];
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        dx_d    = adx;
        dy_d    = -ady;
        err_d   = adx - ady;
        sxn_d   = (x1e < x0e);
        syn_d   = (y1e < y0e);
        cx_d    = x0e;
        cy_d    = y0e;
        state_d = S_STEP;
      end
      S_STEP: begin
        if (adv) begin
          if (at_end) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            if (e2 >= dys) begin
              err_d = err_d + dy_q;
              cx_d  = sxn_q ? (cx_q - ONE)
                            : (cx_q + ONE);
            end
            if (e2 <= dxs) begin
              err_d = err_d + dx_q;
              cy_d  = syn_q ? (cy_q - ONE)
                            : (cy_q + ONE);
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO storage needs no reset; pointers define contents
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // control and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      state_q <= S_IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      col_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      err_q   <= '0;
      sxn_q   <= 1'b0;
      syn_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      col_q   <= col_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      err_q   <= err_d;
      sxn_q   <= sxn_d;
      syn_q   <= syn_d;
      done_q  <= done_d;
    end
  end

  assign cmd_ready = !full;
  assign px_valid  = in_step && vis;
  assign px_x      = cx_q[XW-1:0];
  assign px_y      = cy_q[YW-1:0];
  assign px_color  = col_q;
  assign px_last   = px_valid && at_end;
  assign done      = done_q;
  assign busy      = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_line_raster_engine.sv
// tb_line_raster_engine: scoreboard bench for line_raster_engine.
// Reference pixels come from an integer Bresenham model; a monitor checks the stream.
module tb_line_raster_engine;

  localparam int XW = 11;
  localparam int YW = 10;
  localparam int CW = 24;
  localparam int HA = 800;
  localparam int VA = 480;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [XW-1:0] cmd_x0 = '0;
  logic [YW-1:0] cmd_y0 = '0;
  logic [XW-1:0] cmd_x1 = '0;
  logic [YW-1:0] cmd_y1 = '0;
  logic [CW-1:0] cmd_color = '0;
  logic          px_valid;
  logic          px_ready = 1'b1;
  logic [XW-1:0] px_x;
  logic [YW-1:0] px_y;
  logic [CW-1:0] px_color;
  logic          px_last;
  logic          done;
  logic          busy;

  always #5 clk = ~clk;

  line_raster_engine #(
    .XW(XW), .YW(YW), .CW(CW), .QDEPTH(2),
    .H_ACTIVE(HA), .V_ACTIVE(VA)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0),
    .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color),
    .px_valid(px_valid), .px_ready(px_ready),
    .px_x(px_x), .px_y(px_y),
    .px_color(px_color), .px_last(px_last),
    .done(done), .busy(busy)
  );

  typedef struct {
    int x;
    int y;
    logic [CW-1:0] c;
    bit last;
  } px_t;

  px_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  lines_exp = 0;
  int  done_cnt = 0;
  int  px_seen = 0;
  bit  hold_mon = 1'b1;
  int  ready_mode = 1;
  int  pat_i = 0;
  logic [6:0] pat = 7'b1101001;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] pk(int x, int y, logic [CW-1:0] c, bit l);
    logic [XW-1:0] xs;
    logic [YW-1:0] ys;
    xs = x[XW-1:0];
    ys = y[YW-1:0];
    return 64'({xs, ys, c, l});
  endfunction

  // reference: integer Bresenham walk, endpoint inclusive
  function automatic void model(int x0, int y0, int x1, int y1, logic [CW-1:0] c);
    int dx, dy, sx, sy, err, e2, x, y;
    px_t p;
    dx = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy = -((y1 > y0) ? y1 - y0 : y0 - y1);
    sx = (x0 < x1) ? 1 : -1;
    sy = (y0 < y1) ? 1 : -1;
    err = dx + dy;
    x = x0;
    y = y0;
    forever begin
      p.x = x;
      p.y = y;
      p.c = c;
      p.last = (x == x1) && (y == y1);
`ifdef LINE_RASTER_CLIP_EN
      if (x < HA && y < VA) exp_q.push_back(p);
`else
      exp_q.push_back(p);
`endif
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
    lines_exp++;
  endfunction

  // sink readiness
  always @(negedge clk) begin
    case (ready_mode)
      0: px_ready = ($urandom_range(0, 3) != 0);
      1: px_ready = 1'b1;
      2: px_ready = 1'b0;
      default: begin
        px_ready = (pat_i < 7) ? pat[pat_i] : 1'b1;
        if (pat_i < 7) pat_i++;
      end
    endcase
  end

  // monitor: pop and compare every accepted pixel
  initial begin : mon
    bit stall;
    bit last_hs;
    logic [63:0] held;
    logic [63:0] cur;
    px_t e;
    stall = 1'b0;
    last_hs = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      #1;
      if (hold_mon) begin
        stall = 1'b0;
        last_hs = 1'b0;
        continue;
      end
      if (done) done_cnt++;
`ifndef LINE_RASTER_CLIP_EN
      if (last_hs || done)
        check("done_after_last", 64'(done), 64'(last_hs));
`endif
      cur = pk(int'(px_x), int'(px_y), px_color, px_last);
      if (stall)
        check("stall_hold", {63'(cur), px_valid}, {63'(held), 1'b1});
      stall = 1'b0;
      last_hs = 1'b0;
      if (px_valid) begin
        if (px_ready) begin
          px_seen++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_px: got %0h expected none", cur);
          end else begin
            e = exp_q.pop_front();
            check("pixel", cur, pk(e.x, e.y, e.c, e.last));
          end
          last_hs = px_last;
        end else begin
          stall = 1'b1;
          held = cur;
        end
      end
    end
  end

  task automatic push(int x0, int y0, int x1, int y1, logic [CW-1:0] c);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_x0 = x0[XW-1:0];
    cmd_y0 = y0[YW-1:0];
    cmd_x1 = x1[XW-1:0];
    cmd_y1 = y1[YW-1:0];
    cmd_color = c;
    #1;
    while (!cmd_ready && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!cmd_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL push_timeout: got cmd_ready 0 expected 1");
    end else begin
      model(x0, y0, x1, y1, c);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while ((busy || exp_q.size() != 0) && n < budget);
    n_cmp++;
    if (busy || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_valid(int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (!px_valid && n < budget);
    if (!px_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL valid_timeout: got px_valid 0 expected 1");
    end
  endtask

  initial begin : stim
    int base, run, n;
    int x0, y0, x1, y1, kind;

    repeat (3) @(negedge clk);
    #2;
    check("rst_px_valid", 64'(px_valid), 64'(0));
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_px_last", 64'(px_last), 64'(0));
    check("rst_px_xyc", 64'({px_x, px_y, px_color}), 64'(0));
    reset_n = 1'b1;
    hold_mon = 1'b0;

    // horizontal run, latency and back-to-back pixels
    base = px_seen;
    push(10, 5, 14, 5, 24'hA1B2C3);
    @(negedge clk);
    #2;
    check("lat_edge1", 64'(px_valid), 64'(0));
    @(negedge clk);
    #2;
    check("lat_edge2", 64'(px_valid), 64'(1));
    run = 1;
    n = 0;
    forever begin
      @(negedge clk);
      #2;
      n++;
      if (!px_valid || n > 20) break;
      run++;
    end
    check("t1_run", 64'(run), 64'(5));
    wait_idle(200);
    check("t1_count", 64'(px_seen - base), 64'(5));

    // steep negative octant
    base = px_seen;
    push(3, 9, 1, 2, 24'h00FF00);
    wait_idle(200);
    check("t2_count", 64'(px_seen - base), 64'(8));

    // diagonal under a fixed stall pattern
    base = px_seen;
    ready_mode = 2;
    push(0, 0, 3, 3, 24'h123456);
    wait_valid(50);
    pat_i = 0;
    ready_mode = 3;
    wait_idle(200);
    check("t3_count", 64'(px_seen - base), 64'(4));

    // fill the FIFO under backpressure, then drain in order
    base = px_seen;
    ready_mode = 2;
    push(20, 1, 23, 1, 24'h111111);
    push(7, 7, 7, 7, 24'h222222);
    push(5, 5, 2, 3, 24'h333333);
    @(negedge clk);
    #2;
    check("t4_cmd_ready_full", 64'(cmd_ready), 64'(0));
    check("t4_busy", 64'(busy), 64'(1));
    ready_mode = 1;
    wait_idle(300);
    check("t4_count", 64'(px_seen - base), 64'(9));

    // reset in the middle of a line
    ready_mode = 1;
    push(0, 0, 9, 0, 24'hDEAD01);
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (!(px_valid && px_x == 2) && n < 50);
    check("t5_reached_px2", 64'(px_x), 64'(2));
    hold_mon = 1'b1;
    reset_n = 1'b0;
    exp_q.delete();
    lines_exp--;
    @(negedge clk);
    #2;
    check("t5_px_valid", 64'(px_valid), 64'(0));
    check("t5_busy", 64'(busy), 64'(0));
    check("t5_cmd_ready", 64'(cmd_ready), 64'(1));
    check("t5_done", 64'(done), 64'(0));
    reset_n = 1'b1;
    hold_mon = 1'b0;
    base = px_seen;
    push(2, 2, 4, 2, 24'h0000AA);
    wait_idle(200);
    check("t5_count", 64'(px_seen - base), 64'(3));

    // line crossing the right edge of the visible area
    base = px_seen;
    push(795, 0, 804, 0, 24'hC0FFEE);
    wait_idle(200);
`ifdef LINE_RASTER_CLIP_EN
    check("t6_count", 64'(px_seen - base), 64'(5));
`else
    check("t6_count", 64'(px_seen - base), 64'(10));
`endif

    // randomized lines, random sink backpressure
    ready_mode = 0;
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin
          x0 = $urandom_range(0, 31); y0 = $urandom_range(0, 31);
          x1 = $urandom_range(0, 31); y1 = $urandom_range(0, 31);
        end
        1: begin
          x0 = $urandom_range(0, 2047); y0 = $urandom_range(0, 1023);
          x1 = x0 + $urandom_range(0, 120) - 60;
          y1 = y0 + $urandom_range(0, 120) - 60;
          if (x1 < 0) x1 = 0;
          if (x1 > 2047) x1 = 2047;
          if (y1 < 0) y1 = 0;
          if (y1 > 1023) y1 = 1023;
        end
        2: begin
          x0 = $urandom_range(780, 820); y0 = $urandom_range(460, 500);
          x1 = $urandom_range(780, 820); y1 = $urandom_range(460, 500);
        end
        default: begin
          x0 = $urandom_range(0, 2047); y0 = $urandom_range(0, 1023);
          x1 = x0; y1 = y0;
        end
      endcase
      push(x0, y0, x1, y1, CW'($urandom));
    end
    wait_idle(40000);
    check("done_count", 64'(done_cnt), 64'(lines_exp));
    check("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
